// File: rtl/mem_unit_hs.sv
// rtl/mem_unit_hs.sv - handshake-fronted single-port RAM with wait states, byte enables and range errors
//
// Purpose: sits between the CPU bus controller and the RAM array, modelling
// slow SRAM by inserting WAIT idle edges before each access. A request is
// latched when the block is IDLE or DONE; the access happens WAIT+1 edges
// later and ACK pulses for the following cycle.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   req_i    transaction request, sampled only in IDLE/DONE
//   webar_i  0 = write, 1 = read (latched with req_i)
//   a_i      word address (latched with req_i)
//   wd_i     write data (latched with req_i)
//   be_i     per-byte write enables (latched with req_i, ignored on reads)
//   rd_o     registered read data, holds until the next read completes
//   ack_o    one-cycle completion pulse
//   err_o    one-cycle pulse alongside ack_o for an out-of-range address
//   busy_o   high while the transaction sits in wait states
module mem_unit_hs #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 2 ** AW,
  parameter int WAIT  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            webar_i,
  input  logic [AW-1:0]   a_i,
  input  logic [DW-1:0]   wd_i,
  input  logic [DW/8-1:0] be_i,
  output logic [DW-1:0]   rd_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int NB = DW / 8;
  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**AW is representable for the range check.
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_L  = CW'(WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            webar_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wd_q;
  logic [NB-1:0]   be_q;
  logic [DW-1:0]   rd_q;
  logic            err_q;
  logic            accept;
  logic            access;
  logic            in_range;
  logic            write_en;
  logic [IW-1:0]   idx;

  logic [DW-1:0]   mem [DEPTH];

  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign idx      = addr_q[IW-1:0];
  // Gating with rst_i keeps an aborted write from landing even if reset
  // and the access edge coincide.
  assign write_en = access && !webar_q && in_range && !rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = WAIT_L;
          state_d = WAITING;
        end else begin
          state_d = IDLE;
        end
      end
      WAITING: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      webar_q <= 1'b1;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        webar_q <= webar_i;
        addr_q  <= a_i;
        wd_q    <= wd_i;
        be_q    <= be_i;
      end
      if (access) begin
        err_q <= !in_range;
        // Writes leave rd_q alone; out-of-range reads return zero.
        if (webar_q) begin
          rd_q <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

  // RAM array has no reset: contents survive rst_i.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (write_en && be_q[i]) begin
        mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

  // ack/err derive from state so an asynchronous reset in DONE drops them at once.
  assign ack_o  = (state_q == DONE);
  assign err_o  = (state_q == DONE) && err_q;
  assign busy_o = (state_q == WAITING);
  assign rd_o   = rd_q;

endmodule

// File: tb/tb_mem_unit_hs.sv
// tb/tb_mem_unit_hs.sv - directed self-checking bench for mem_unit_hs
module tb_mem_unit_hs;

  logic        clk;
  logic        rst;
  logic        req0, webar0, ack0, err0, busy0;
  logic [15:0] a0, wd0, rd0;
  logic [1:0]  be0;
  logic        req1, webar1, ack1, err1, busy1;
  logic [15:0] a1, wd1, rd1;
  logic [1:0]  be1;

  int checks = 0;
  int errors = 0;
  int lat, busyc, acks;

  mem_unit_hs #(.DW(16), .AW(16), .DEPTH(256), .WAIT(2)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .webar_i(webar0), .a_i(a0),
    .wd_i(wd0), .be_i(be0), .rd_o(rd0), .ack_o(ack0), .err_o(err0), .busy_o(busy0)
  );

  mem_unit_hs #(.DW(16), .AW(16), .DEPTH(256), .WAIT(0)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .webar_i(webar1), .a_i(a1),
    .wd_i(wd1), .be_i(be1), .rd_o(rd1), .ack_o(ack1), .err_o(err1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on u0, scrambles the inputs after the accepting edge,
  // and returns #1 after the edge where ack0 is seen (or after a 20-edge budget).
  task automatic xact0(input logic wb, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] be, output int l, output int bc);
    webar0 = wb; a0 = a; wd0 = wd; be0 = be; req0 = 1'b1;
    tick();
    req0 = 1'b0; webar0 = ~wb; a0 = 16'hFFFF; wd0 = ~wd; be0 = 2'b11;
    l = 0; bc = 0;
    while (!ack0 && l < 20) begin
      if (busy0) bc++;
      tick();
      l++;
    end
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; webar0 = 1'b1; a0 = '0; wd0 = '0; be0 = '0;
    req1 = 1'b0; webar1 = 1'b1; a1 = '0; wd1 = '0; be1 = '0;
    #1 rst = 1'b1;

    // Reset with REQ toggling
    for (int i = 0; i < 4; i++) begin
      req0 = ~req0;
      req1 = ~req1;
      tick();
    end
    check("rst_rd", rd0, 16'h0000);
    check("rst_ack", ack0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b0;

    // First request after reset: write 0x1234 to 0x0005
    xact0(1'b0, 16'h0005, 16'h1234, 2'b11, lat, busyc);
    check("wr_latency", lat, 3);
    check("wr_busy_cycles", busyc, 3);
    check("wr_err", err0, 1'b0);
    check("wr_rd_unchanged", rd0, 16'h0000);

    xact0(1'b1, 16'h0005, 16'h0000, 2'b00, lat, busyc);
    check("rd_latency", lat, 3);
    check("rd_data", rd0, 16'h1234);
    check("rd_err", err0, 1'b0);
    tick();
    check("ack_one_cycle", ack0, 1'b0);
    tick();
    check("rd_hold", rd0, 16'h1234);

    // Byte enable: low byte only
    xact0(1'b0, 16'h0005, 16'hABCD, 2'b01, lat, busyc);
    check("be_wr_ack", ack0, 1'b1);
    xact0(1'b1, 16'h0005, 16'h0000, 2'b00, lat, busyc);
    check("be_rd_data", rd0, 16'h12CD);

    // BE=0 write completes and changes nothing
    xact0(1'b0, 16'h0005, 16'h0000, 2'b00, lat, busyc);
    check("be0_ack_latency", lat, 3);
    xact0(1'b1, 16'h0005, 16'h0000, 2'b00, lat, busyc);
    check("be0_rd_data", rd0, 16'h12CD);

    // Out of range at DEPTH=256
    xact0(1'b0, 16'h0000, 16'h0F0F, 2'b11, lat, busyc);
    xact0(1'b1, 16'h0100, 16'h0000, 2'b00, lat, busyc);
    check("oor_rd_ack", ack0, 1'b1);
    check("oor_rd_err", err0, 1'b1);
    check("oor_rd_data", rd0, 16'h0000);
    tick();
    check("oor_err_pulse", err0, 1'b0);
    xact0(1'b0, 16'h0100, 16'hFFFF, 2'b11, lat, busyc);
    check("oor_wr_err", err0, 1'b1);
    xact0(1'b1, 16'h0000, 16'h0000, 2'b00, lat, busyc);
    check("oor_alias_data", rd0, 16'h0F0F);
    check("oor_alias_err", err0, 1'b0);

    // REQ pulse confined to WAITING is ignored
    tick();
    webar0 = 1'b1; a0 = 16'h0005; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack0) acks++;
      tick();
    end
    check("ignore_ack_count", acks, 1);

    // Reset in the middle of a write
    xact0(1'b0, 16'h0010, 16'h2222, 2'b11, lat, busyc);
    xact0(1'b1, 16'h0010, 16'h0000, 2'b00, lat, busyc);
    check("pre_abort_data", rd0, 16'h2222);
    tick();
    webar0 = 1'b0; a0 = 16'h0010; wd0 = 16'h5555; be0 = 2'b11; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    check("abort_busy_before", busy0, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy_async", busy0, 1'b0);
    check("abort_rd_reset", rd0, 16'h0000);
    tick();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (ack0) acks++;
      tick();
    end
    check("abort_no_ack", acks, 0);
    xact0(1'b1, 16'h0010, 16'h0000, 2'b00, lat, busyc);
    check("abort_mem_kept", rd0, 16'h2222);

    // Back-to-back at WAIT=0: REQ high for 6 edges
    webar1 = 1'b0; a1 = 16'h0001; wd1 = 16'h0000; be1 = 2'b00; req1 = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) req1 = 1'b0;
      if (ack1) acks++;
      if (i == 1) check("b2b_ack_at_2", ack1, 1'b1);
      if (i == 2) check("b2b_noack_at_3", ack1, 1'b0);
    end
    check("b2b_ack_count", acks, 3);
    check("b2b_err", err1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_unit_hs.md
# mem_unit_hs

Parametrised successor to the memory unit: single-port synchronous RAM with configurable data width, address width, depth and wait-state count, fronted by a request/acknowledge handshake. It sits between the CPU bus controller and the RAM array and models slow breadboard SRAM timing. It adds per-byte write enables and out-of-range error reporting. The write strobe stays active-low as on the existing unit.

## Interface
- DW, 16: data width in bits; must be a multiple of 8.
- AW, 16: address width in bits.
- DEPTH, 2**AW: number of implemented words; must be ≤ 2**AW.
- WAIT, 2: wait states added per access; legal range 0..15.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- REQ  in  1  transaction request; sampled only when the block can accept.
- WEBAR  in  1  0 = write, 1 = read; latched with REQ.
- A  in  AW  word address; latched with REQ.
- WD  in  DW  write data; latched with REQ.
- BE  in  DW/8  byte enables for writes; bit i covers WD[8i+7:8i]; ignored on reads.
- RD  out  DW  registered read data.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle pulse with ACK when the address was out of range.
- BUSY  out  1  high while a transaction is in wait states.

## Operation
- States: IDLE, WAITING, DONE. BUSY = (state == WAITING).
- Accept:
  - In IDLE or DONE, REQ=1 at an edge latches WEBAR, A, WD and BE.
  - It loads the wait counter with WAIT and moves the block to WAITING.
- WAITING:
  - If counter ≠ 0, decrement each edge.
  - If counter = 0, perform the access at that edge and go to DONE.
- Access, read:
  - A < DEPTH: RD ← mem[A].
  - A ≥ DEPTH: RD ← 0 and ERR=1.
- Access, write:
  - A < DEPTH: for each i with BE[i]=1, mem[A] byte i ← WD byte i. RD is unchanged.
  - A ≥ DEPTH: memory is unchanged and ERR=1. There is no aliasing onto A mod DEPTH.
- DONE:
  - ACK=1 for exactly this cycle.
  - REQ=1 here starts a new transaction (back-to-back). Otherwise go to IDLE.
- REQ during WAITING is ignored, not queued. The requester must hold REQ until it sees ACK or re-issue it.
- Input changes after the accepting edge have no effect on the transaction in flight.
- Write with BE=0: completes with ACK and changes nothing.

## Timing
- Reset values: RD=0, ACK=0, ERR=0, BUSY=0, state IDLE, counter 0.
- RAM contents are not cleared by RST.
- Latency: REQ accepted at edge k, access performed at edge k+WAIT+1, ACK high during the cycle after that edge.
  - WAIT=0 gives a 1-edge latency.
  - BUSY is high for WAIT+1 cycles.
- Read data: RD is valid in the ACK cycle and holds until the next read completes or RST is asserted.
- Throughput: back-to-back accepts give one transaction every WAIT+2 cycles.
- RST during WAITING: the transaction is aborted immediately. No memory write occurs and no ACK follows.
- RST during DONE: ACK and ERR drop asynchronously.
- Counter width: clog2(WAIT+1), minimum 1 bit.

## Test plan
- Reset: with RST=1 and REQ toggling, RD=0x0000, ACK=0, ERR=0, BUSY=0. Release RST; the first REQ is accepted on the next edge.
- Write/read, WAIT=2:
  - Write A=0x0005, WD=0x1234, BE=2'b11. ACK goes high 3 edges after accept, with BUSY high for 3 cycles before it.
  - Read A=0x0005. RD=0x1234 in the ACK cycle.
- Byte enables: after 0x1234 is at 0x0005, write WD=0xABCD with BE=2'b01. A subsequent read returns 0x12CD.
- Back-to-back and ignore, WAIT=0:
  - REQ held high for 6 cycles gives ACK every 2nd cycle.
  - A REQ pulse that falls entirely in WAITING produces no extra ACK.
- Out-of-range, DEPTH=256:
  - Read A=0x0100 gives ACK=1, ERR=1, RD=0x0000.
  - Write 0xFFFF to A=0x0100, then read A=0x0000: unchanged, ERR=0.
- Reset mid-write:
  - Assert RST for 1 cycle during WAITING of a write of 0x5555 to A=0x0010. No ACK appears.
  - A later read of 0x0010 returns its prior value.
